// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive-side control logic.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned DEFAULT_DATA_W  = 8;

    // Byte-capture handshake with the receiver.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_ctrl_state_t;

    // Divisor to program into baud_div for a given clock and baud rate.
    function automatic int unsigned baud_div_for(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz / (UART_OVERSAMPLE * baud)) - 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running counter that strobes rx_enb for one
// cycle each time it reaches baud_div, then restarts from zero.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         enables counting; when low the counter is held at zero
//   baud_div   tick period minus one
//   rx_enb     registered one-cycle oversample strobe
module uart_baud_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] baud_div,
    output logic             rx_enb
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             rx_enb_q, rx_enb_d;

    // >= rather than == so a divisor lowered below the current count wraps at once.
    always_comb begin
        cnt_d    = '0;
        rx_enb_d = 1'b0;
        if (en) begin
            if (cnt_q >= baud_div) begin
                rx_enb_d = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            rx_enb_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rx_enb_q <= rx_enb_d;
        end
    end

    assign rx_enb = rx_enb_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: drives the receiver's oversample strobe, captures
// each completed byte with a rdy/rdy_clr handshake, and buffers bytes in a
// small FIFO exposed as a valid/ready stream with sticky overrun.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, baud_div        oversample tick enable and period-1
//   rx_rdy, rx_data     receiver byte-ready level and byte
//   rx_enb, rdy_clr     oversample strobe and byte acknowledge to receiver
//   m_data, m_valid,
//   m_ready             registered FIFO head stream
//   fifo_count          occupancy 0..FIFO_DEPTH
//   overrun, ovr_clr    sticky drop flag and its clear
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        rx_rdy,
    input  logic [DATA_W-1:0]           rx_data,
    output logic                        rx_enb,
    output logic                        rdy_clr,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    input  logic                        ovr_clr
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .baud_div (baud_div),
        .rx_enb   (rx_enb)
    );

    rx_ctrl_state_t    state_q, state_d;
    logic              rdy_clr_q, rdy_clr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              overrun_q, overrun_d;
    logic              push_req, pop, full, do_push;

    // Capture handshake: one push on entry to ACK; rdy_clr mirrors the ACK state.
    always_comb begin
        state_d   = state_q;
        rdy_clr_d = 1'b0;
        push_req  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    push_req = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!rx_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_clr_d = (state_d == ACK);
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees the head slot.
    always_comb begin
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        pop       = m_valid_q && m_ready;
        do_push   = push_req && (!full || pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = rx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Set has priority over a simultaneous clear.
        if (push_req && full && !pop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        // Head is registered from the post-update storage, so no fall-through.
        m_data_d  = mem_d[rd_ptr_d];
        m_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rdy_clr_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rdy_clr_q <= rdy_clr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdy_clr    = rdy_clr_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] baud_div = 16'd3;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_enb;
    logic        rdy_clr;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  fifo_count;
    logic        overrun;
    logic        ovr_clr = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    uart_rx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_div   (baud_div),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_enb     (rx_enb),
        .rdy_clr    (rdy_clr),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_count (fifo_count),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte queue, sticky flag, tick phase, handshake flag.
    logic [7:0] mq[$];
    int         m_tcnt   = 0;
    bit         m_enb    = 1'b0;
    bit         m_ack    = 1'b0;
    bit         m_ovr    = 1'b0;
    bit         m_was_rst = 1'b0;

    always @(posedge clk) begin
        bit push, pop, full;
        if (rst) begin
            mq.delete();
            m_tcnt = 0; m_enb = 1'b0; m_ack = 1'b0; m_ovr = 1'b0;
            m_was_rst = 1'b1;
        end else begin
            m_was_rst = 1'b0;
            if (!en) begin
                m_tcnt = 0; m_enb = 1'b0;
            end else if (m_tcnt >= int'(baud_div)) begin
                m_tcnt = 0; m_enb = 1'b1;
            end else begin
                m_tcnt++; m_enb = 1'b0;
            end
            push  = !m_ack && rx_rdy;
            m_ack = rx_rdy;
            pop   = (mq.size() > 0) && m_ready;
            full  = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (push && full && !pop) m_ovr = 1'b1;
            else begin
                if (ovr_clr) m_ovr = 1'b0;
                if (push) mq.push_back(rx_data);
            end
        end
        #2;
        chk("rx_enb", 32'(rx_enb), 32'(m_enb));
        chk("rdy_clr", 32'(rdy_clr), 32'(m_ack));
        chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (mq.size() > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
        else if (m_was_rst) chk("m_data_rst", 32'(m_data), 32'h0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Receiver emulation: present a byte, hold until acknowledged, then release.
    task automatic send_byte(input logic [7:0] b);
        bit acked = 1'b0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (rdy_clr) begin
                acked = 1'b1;
                break;
            end
        end
        if (!acked) chk("ack_timeout", 32'(0), 32'(1));
        rx_rdy = 1'b0;
        cyc();
    endtask

    logic [7:0] drained[$];

    task automatic drain();
        drained.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 20 && m_valid; i++) begin
            drained.push_back(m_data);
            cyc();
        end
        m_ready = 1'b0;
        cyc();
    endtask

    initial begin
        int pulses;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_count", 32'(fifo_count), 32'h0);
        chk("reset_valid", 32'(m_valid), 32'h0);

        // T1: oversample strobe period with baud_div=3
        baud_div = 16'd3;
        en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (rx_enb) pulses++;
        end
        chk("t1_pulses", 32'(pulses), 32'd4);
        en = 1'b0;
        cyc(); chk("t1_en_off", 32'(rx_enb), 32'h0);
        cyc(); chk("t1_en_off2", 32'(rx_enb), 32'h0);

        // T2: single byte capture
        rx_data = 8'hA5; rx_rdy = 1'b1;
        cyc();
        chk("t2_rdy_clr", 32'(rdy_clr), 32'h1);
        chk("t2_valid", 32'(m_valid), 32'h1);
        chk("t2_data", 32'(m_data), 32'hA5);
        chk("t2_count", 32'(fifo_count), 32'h1);
        rx_rdy = 1'b0;
        cyc(); cyc(); cyc();
        chk("t2_one_push", 32'(fifo_count), 32'h1);
        chk("t2_clr_drop", 32'(rdy_clr), 32'h0);
        drain();

        // T3: overflow by one, then drain in order
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        chk("t3_count", 32'(fifo_count), 32'd8);
        chk("t3_overrun", 32'(overrun), 32'h1);
        drain();
        chk("t3_len", 32'(drained.size()), 32'd8);
        for (int i = 0; i < drained.size(); i++) chk("t3_order", 32'(drained[i]), 32'(i + 1));

        // T4: push and pop in the same cycle while full
        ovr_clr = 1'b1; cyc(); ovr_clr = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
        rx_data = 8'h20; rx_rdy = 1'b1; m_ready = 1'b1;
        cyc();
        m_ready = 1'b0; rx_rdy = 1'b0;
        cyc();
        chk("t4_count", 32'(fifo_count), 32'd8);
        chk("t4_overrun", 32'(overrun), 32'h0);
        drain();
        chk("t4_len", 32'(drained.size()), 32'd8);
        if (drained.size() == 8) begin
            chk("t4_first", 32'(drained[0]), 32'h11);
            chk("t4_last", 32'(drained[7]), 32'h20);
        end

        // T5: set beats simultaneous clear; clear alone works
        for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i));
        ovr_clr = 1'b1; rx_data = 8'h99; rx_rdy = 1'b1;
        cyc();
        chk("t5_set_wins", 32'(overrun), 32'h1);
        ovr_clr = 1'b0; rx_rdy = 1'b0;
        cyc();
        ovr_clr = 1'b1;
        cyc();
        chk("t5_clear", 32'(overrun), 32'h0);
        ovr_clr = 1'b0;
        drain();

        // T6: reset while acknowledging with three bytes buffered
        en = 1'b1;
        send_byte(8'h41); send_byte(8'h42);
        rx_data = 8'h43; rx_rdy = 1'b1;
        cyc(); cyc();
        chk("t6_pre_count", 32'(fifo_count), 32'd3);
        chk("t6_pre_ack", 32'(rdy_clr), 32'h1);
        rst = 1'b1;
        cyc();
        chk("t6_count", 32'(fifo_count), 32'h0);
        chk("t6_valid", 32'(m_valid), 32'h0);
        chk("t6_rdy_clr", 32'(rdy_clr), 32'h0);
        chk("t6_rx_enb", 32'(rx_enb), 32'h0);
        chk("t6_data", 32'(m_data), 32'h0);
        rst = 1'b0; rx_rdy = 1'b0;
        cyc(); cyc();

        // Randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 29) == 0) baud_div = 16'($urandom_range(0, 5));
            m_ready = ($urandom_range(0, 9) < 4);
            ovr_clr = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            if (!rx_rdy) begin
                if ($urandom_range(0, 9) < 4) begin
                    rx_data = 8'($urandom);
                    rx_rdy  = 1'b1;
                end
            end else if (rdy_clr && $urandom_range(0, 9) < 6) begin
                rx_rdy = 1'b0;
            end
            cyc();
        end
        rst = 1'b0; rx_rdy = 1'b0; m_ready = 1'b0; ovr_clr = 1'b0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
